// File: rtl/riscv_step_controller.sv
// riscv_step_controller: multi-cycle control FSM stepping the RV32I datapath one instruction at a time.
// Latency: FETCH to next FETCH is ALU 4, LOAD 5+N, STORE 4+N, BRANCH 3 cycles (N = mem_ready wait cycles).
// Backpressure: MEM holds its strobe until mem_ready is sampled; halt_req is honoured only at instruction boundaries.
// Optional build macro RISCV_STEP_CTRL_PERF_EN adds the retired_count output.
module riscv_step_controller #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic [6:0]        instr_opcode,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              fetch_en,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              busy,
  output logic              done,
  output logic              illegal
`ifdef RISCV_STEP_CTRL_PERF_EN
  ,
  output logic [31:0]       retired_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH
  } cls_t;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  state_t            state_nxt;
  cls_t              cls_q;
  cls_t              cls_dec;
  logic              dec_exec;
  logic              dec_sys;
  logic              boundary;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;

  // Classify the opcode presented during DECODE
  always_comb begin
    cls_dec  = C_ALU;
    dec_exec = 1'b1;
    dec_sys  = 1'b0;
    case (instr_opcode)
      7'b0110011, 7'b0010011, 7'b0110111: cls_dec = C_ALU;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      7'b1110011: begin
        dec_exec = 1'b0;
        dec_sys  = 1'b1;
      end
      default:    dec_exec = 1'b0;
    endcase
  end

  // Instruction boundary: the cycle in which an instruction retires and halt_req is sampled
  always_comb begin
    boundary = 1'b0;
    case (state)
      S_EXEC:  boundary = (cls_q == C_BRANCH);
      S_MEM:   boundary = mem_ready && (cls_q == C_STORE);
      S_WB:    boundary = 1'b1;
      default: boundary = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_DECODE;
      S_DECODE:       state_nxt = dec_exec ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (cls_q == C_LOAD || cls_q == C_STORE) begin
          state_nxt = S_MEM;
        end else if (cls_q == C_ALU) begin
          state_nxt = S_WB;
        end
      end
      S_MEM:          if (mem_ready && cls_q == C_LOAD) state_nxt = S_WB;
      S_WB:           state_nxt = S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
    if (boundary) begin
      state_nxt = halt_req ? S_HALT : S_FETCH;
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    fetch_en  = (state == S_FETCH);
    reg_write = (state == S_WB);
    mem_read  = (state == S_MEM) && (cls_q == C_LOAD);
    mem_write = (state == S_MEM) && (cls_q == C_STORE);
    busy      = (state != S_IDLE) && (state != S_HALT);
    done      = (state == S_HALT);
  end

  // PC update: taken branch jumps to the word-aligned target, any other retirement steps by 4
  always_comb begin
    pc_nxt = pc_q;
    if (state == S_EXEC && cls_q == C_BRANCH && branch_taken) begin
      pc_nxt = branch_target & ALIGN_MASK;
    end else if (boundary) begin
      pc_nxt = pc_q + PC_STEP;
    end
  end

  // PC, latched opcode class and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      cls_q   <= C_ALU;
      illegal <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (state == S_DECODE) begin
        cls_q <= cls_dec;
        if (!dec_exec && !dec_sys) begin
          illegal <= 1'b1;
        end
      end
    end
  end

  assign instr_addr = pc_q;

`ifdef RISCV_STEP_CTRL_PERF_EN
  // Count retired instructions; SYSTEM and illegal opcodes never reach a boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count <= '0;
    end else if (boundary) begin
      retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_step_controller.sv
// tb_riscv_step_controller: randomized instruction-level stimulus against an instruction-sequence model.
// Latency: the model expands each instruction into its expected per-cycle output pattern.
// Backpressure: mem_ready wait counts are drawn per instruction; halt_req is random off-boundary.
module tb_riscv_step_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic [6:0]  instr_opcode;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        mem_ready;
  logic [31:0] instr_addr;
  logic        fetch_en;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        busy;
  logic        done;
  logic        illegal;
`ifdef RISCV_STEP_CTRL_PERF_EN
  logic [31:0] retired_count;
  logic [31:0] m_ret;
  logic [31:0] e_ret;
`endif

  always #5 clk = ~clk;

  riscv_step_controller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .halt_req      (halt_req),
    .instr_opcode  (instr_opcode),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_ready     (mem_ready),
    .instr_addr    (instr_addr),
    .fetch_en      (fetch_en),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal)
`ifdef RISCV_STEP_CTRL_PERF_EN
    ,
    .retired_count (retired_count)
`endif
  );

  // Model state
  logic [31:0] m_pc;
  logic        m_ill;
  bit          parked;
  bit          m_done;

  // Expected outputs for the current cycle
  logic [31:0] e_addr;
  logic [5:0]  e_ctl;
  logic        e_ill;
  bit          chk_en = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic [6:0] alu_ops [3] = '{7'b0110011, 7'b0010011, 7'b0110111};

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if ({instr_addr, fetch_en, reg_write, mem_read, mem_write, busy, done, illegal} !== {e_addr, e_ctl, e_ill}) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got addr=%h fe,rw,mr,mw,busy,done=%b ill=%b; expected addr=%h ctl=%b ill=%b",
                 $time, instr_addr, {fetch_en, reg_write, mem_read, mem_write, busy, done}, illegal,
                 e_addr, e_ctl, e_ill);
      end
      n_chk++;
      if ($countones({fetch_en, reg_write, mem_read, mem_write}) > 1) begin
        n_fail++;
        $display("FAIL strobe_exclusive t=%0t: got fe,rw,mr,mw=%b, expected at most one high",
                 $time, {fetch_en, reg_write, mem_read, mem_write});
      end
`ifdef RISCV_STEP_CTRL_PERF_EN
      n_chk++;
      if (retired_count !== e_ret) begin
        n_fail++;
        $display("FAIL retired_count t=%0t: got %0d, expected %0d", $time, retired_count, e_ret);
      end
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic retire_one;
`ifdef RISCV_STEP_CTRL_PERF_EN
    m_ret = m_ret + 32'd1;
`endif
  endtask

  task automatic model_reset;
    m_pc   = 32'h0;
    m_ill  = 1'b0;
    parked = 1'b1;
    m_done = 1'b0;
`ifdef RISCV_STEP_CTRL_PERF_EN
    m_ret  = 32'h0;
`endif
  endtask

  // Random values on every input; callers then pin whatever the cycle actually samples
  task automatic junk;
    reset         = 1'b0;
    start         = 1'($urandom);
    halt_req      = 1'($urandom);
    instr_opcode  = 7'($urandom);
    branch_taken  = 1'($urandom);
    branch_target = $urandom;
    mem_ready     = 1'($urandom);
  endtask

  task automatic set_exp(input bit fe, input bit rw, input bit mr, input bit mw, input bit bz, input bit dn);
    e_addr = m_pc;
    e_ctl  = {fe, rw, mr, mw, bz, dn};
    e_ill  = m_ill;
`ifdef RISCV_STEP_CTRL_PERF_EN
    e_ret  = m_ret;
`endif
  endtask

  // 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 SYSTEM, 5 illegal
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111: return 0;
      7'b0000011: return 1;
      7'b0100011: return 2;
      7'b1100011: return 3;
      7'b1110011: return 4;
      default:    return 5;
    endcase
  endfunction

  // Parked in IDLE/HALT for k cycles, then start
  task automatic wait_go(input int k);
    for (int i = 0; i < k; i++) begin
      junk;
      start = 1'b0;
      set_exp(0, 0, 0, 0, 0, m_done);
      tick;
    end
    junk;
    start = 1'b1;
    set_exp(0, 0, 0, 0, 0, m_done);
    tick;
    parked = 1'b0;
  endtask

  // One instruction from its FETCH cycle up to (not including) the following cycle
  task automatic instr(input logic [6:0] opc, input int nw, input logic tk,
                       input logic [31:0] tg, input logic hr);
    int c;
    bit stop;
    c = cls_of(opc);
    stop = 1'b0;
    junk; set_exp(1, 0, 0, 0, 1, 0); tick;
    junk; instr_opcode = opc; set_exp(0, 0, 0, 0, 1, 0); tick;
    if (c >= 4) begin
      if (c == 5) m_ill = 1'b1;
      stop = 1'b1;
    end else begin
      junk;
      set_exp(0, 0, 0, 0, 1, 0);
      if (c == 3) begin
        branch_taken  = tk;
        branch_target = tg;
        halt_req      = hr;
      end
      tick;
      if (c == 3) begin
        m_pc = tk ? {tg[31:2], 2'b00} : m_pc + 32'd4;
        retire_one;
        stop = hr;
      end else begin
        if (c == 1 || c == 2) begin
          for (int i = 0; i <= nw; i++) begin
            junk;
            mem_ready = (i == nw);
            if (c == 2 && i == nw) halt_req = hr;
            set_exp(0, 0, (c == 1), (c == 2), 1, 0);
            tick;
          end
        end
        if (c == 2) begin
          m_pc = m_pc + 32'd4;
          retire_one;
          stop = hr;
        end else begin
          junk;
          halt_req = hr;
          set_exp(0, 1, 0, 0, 1, 0);
          tick;
          m_pc = m_pc + 32'd4;
          retire_one;
          stop = hr;
        end
      end
    end
    if (stop) begin
      parked = 1'b1;
      m_done = 1'b1;
    end
  endtask

  task automatic go(input logic [6:0] opc, input int nw, input logic tk,
                    input logic [31:0] tg, input logic hr);
    if (parked) wait_go($urandom_range(0, 2));
    instr(opc, nw, tk, tg, hr);
  endtask

  initial begin
    junk;
    reset = 1'b1;
    start = 1'b0;
    tick;
    tick;
    junk;
    model_reset;
    chk_en = 1'b1;
    lit("reset_pc", instr_addr, 32'h0);
    lit("reset_flags", {28'h0, busy, done, illegal, fetch_en}, 32'h0);

    wait_go(2);
    instr(OP_R, 0, 1'b0, 32'h0, 1'b0);
    lit("alu_next_pc", instr_addr, 32'h4);
    lit("alu_next_fetch", {31'h0, fetch_en}, 32'h1);

    go(OP_LOAD, 3, 1'b0, 32'h0, 1'b0);
    lit("load_next_pc", instr_addr, 32'h8);

    go(OP_BRANCH, 0, 1'b1, 32'h103, 1'b0);
    lit("branch_taken_pc", instr_addr, 32'h100);
    go(OP_BRANCH, 0, 1'b0, $urandom, 1'b0);
    lit("branch_not_taken_pc", instr_addr, 32'h104);

    go(OP_R, 0, 1'b0, 32'h0, 1'b0);
    go(7'b1111111, 0, 1'b0, 32'h0, 1'b0);
    lit("illegal_halt", {30'h0, done, illegal}, 32'h3);
    wait_go(1);
    lit("illegal_sticky", {31'h0, illegal}, 32'h1);
    lit("resume_pc", instr_addr, 32'h108);

    instr(OP_STORE, 2, 1'b0, 32'h0, 1'b1);
    lit("store_halt_done", {31'h0, done}, 32'h1);
    lit("store_halt_pc", instr_addr, 32'h10C);
    wait_go(2);
    lit("store_resume_pc", instr_addr, 32'h10C);

    go(OP_SYSTEM, 0, 1'b0, 32'h0, 1'b0);
    lit("system_halt", {30'h0, done, busy}, 32'h2);

    go(OP_BRANCH, 0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    lit("branch_to_top_pc", instr_addr, 32'hFFFF_FFFC);
    go(OP_R, 0, 1'b0, 32'h0, 1'b0);
    lit("pc_wrap", instr_addr, 32'h0);

    for (int n = 0; n < 60; n++) begin
      int r;
      logic [6:0] op;
      r = $urandom_range(0, 19);
      if (r < 4)       op = alu_ops[$urandom_range(0, 2)];
      else if (r < 8)  op = OP_LOAD;
      else if (r < 12) op = OP_STORE;
      else if (r < 16) op = OP_BRANCH;
      else if (r == 16) op = OP_SYSTEM;
      else if (r == 17) op = 7'($urandom);
      else             op = alu_ops[$urandom_range(0, 2)];
      go(op, $urandom_range(0, 4), 1'($urandom), $urandom, ($urandom_range(0, 7) == 0));
    end

    // Reset while a STORE waits on mem_ready
    if (parked) wait_go(0);
    junk; set_exp(1, 0, 0, 0, 1, 0); tick;
    junk; instr_opcode = OP_STORE; set_exp(0, 0, 0, 0, 1, 0); tick;
    junk; set_exp(0, 0, 0, 0, 1, 0); tick;
    for (int i = 0; i < 2; i++) begin
      junk; mem_ready = 1'b0; set_exp(0, 0, 0, 1, 1, 0); tick;
    end
    junk; mem_ready = 1'b0; reset = 1'b1; set_exp(0, 0, 0, 1, 1, 0); tick;
    model_reset;
    lit("midmem_reset_pc", instr_addr, 32'h0);
    lit("midmem_reset_flags", {27'h0, fetch_en, reg_write, mem_read, mem_write, illegal}, 32'h0);
    lit("midmem_reset_busy", {30'h0, busy, done}, 32'h0);

    wait_go(1);
    instr(OP_R, 0, 1'b0, 32'h0, 1'b0);
    instr(OP_BRANCH, 0, 1'b0, $urandom, 1'b0);
    instr(OP_STORE, 1, 1'b0, 32'h0, 1'b0);
    lit("three_instr_pc", instr_addr, 32'hC);
`ifdef RISCV_STEP_CTRL_PERF_EN
    lit("retired_three", retired_count, 32'd3);
`endif
    junk;
    set_exp(1, 0, 0, 0, 1, 0);
    tick;

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
